// File: rtl/spi_master_reader.sv
// spi_master_reader
//   SPI master that reads bytes, MSB first, from the FPGA-side SPI slave
//   transmitter. It generates SCK (idles low) and SSEL (active low, idles
//   high), samples MISO the cycle before each SCK rising edge, and presents
//   every assembled byte with a one-cycle rx_valid strobe and its index in
//   the frame. Each frame reads BYTES_PER_FRAME bytes with SCK running
//   continuously across byte boundaries, followed by a HOLD phase (SSEL
//   still low) and a COOL phase (SSEL high) before the next start.
//
//   Parameters
//     CLK_DIV          SCK half-period in clk cycles (minimum 4)
//     BYTES_PER_FRAME  bytes per SSEL-low frame (1..255)
//
//   Ports
//     clk, rst         clock and synchronous active-high reset
//     start            begin a frame (sampled in IDLE only)
//     busy             frame in progress
//     SCK, SSEL, MISO  SPI pins
//     rx_data          last received byte, held until the next rx_valid
//     rx_valid         one-cycle strobe, rx_data/byte_idx are new
//     byte_idx         0-based index of rx_data within the frame
//     frame_done       one-cycle strobe on the last cycle of a frame
//
//   Optional feature (macro SPI_MASTER_MOSI_EN)
//     Adds tx_data (8-bit input) and MOSI (output). tx_data is loaded at the
//     start of each byte and shifted out MSB first; MOSI changes only as SCK
//     falls and is 0 outside the frame.
module spi_master_reader #(
    parameter int CLK_DIV         = 8,
    parameter int BYTES_PER_FRAME = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       SCK,
    output logic       SSEL,
    input  logic       MISO,
`ifdef SPI_MASTER_MOSI_EN
    input  logic [7:0] tx_data,
    output logic       MOSI,
`endif
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] byte_idx,
    output logic       frame_done
);

    localparam int               DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       BYTE_LAST = 8'(BYTES_PER_FRAME - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, COOL} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [7:0]       byte_cnt, byte_nxt;
    logic [7:0]       shreg;
    logic             div_last;
    logic             sample;      // last LOW cycle: MISO captured at this edge
    logic             byte_start;  // next cycle is the first LOW cycle of a byte
    logic             bit_shift;   // SCK falls inside a byte
    logic             in_frame_nxt;
    logic             done_nxt;
    logic             byte_end;

    assign div_last = (div_cnt == DIV_LAST);
    assign byte_end = sample && (bit_cnt == 3'd7);

    always_comb begin
        state_nxt  = state;
        div_nxt    = div_cnt + 1'b1;
        bit_nxt    = bit_cnt;
        byte_nxt   = byte_cnt;
        sample     = 1'b0;
        byte_start = 1'b0;
        bit_shift  = 1'b0;
        case (state)
            IDLE: begin
                div_nxt = '0;
                if (start) begin
                    state_nxt  = LOW;
                    bit_nxt    = 3'd0;
                    byte_nxt   = 8'd0;
                    byte_start = 1'b1;
                end
            end
            LOW: begin
                if (div_last) begin
                    state_nxt = HIGH;
                    div_nxt   = '0;
                    sample    = 1'b1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_nxt = '0;
                    if (bit_cnt != 3'd7) begin
                        bit_nxt   = bit_cnt + 3'd1;
                        state_nxt = LOW;
                        bit_shift = 1'b1;
                    end else begin
                        bit_nxt  = 3'd0;
                        byte_nxt = byte_cnt + 8'd1;
                        if (byte_cnt == BYTE_LAST) begin
                            state_nxt = HOLD;
                        end else begin
                            // no inter-byte gap: straight into the next LOW
                            state_nxt  = LOW;
                            byte_start = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_nxt = COOL;
                    div_nxt   = '0;
                end
            end
            COOL: begin
                if (div_last) begin
                    state_nxt = IDLE;
                    div_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
            end
        endcase
        in_frame_nxt = (state_nxt == LOW) || (state_nxt == HIGH) || (state_nxt == HOLD);
        done_nxt     = (state_nxt == COOL) && (div_nxt == DIV_LAST);
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 8'd0;
            SCK        <= 1'b0;
            SSEL       <= 1'b1;
            busy       <= 1'b0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            rx_data    <= 8'd0;
            byte_idx   <= 8'd0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            byte_cnt   <= byte_nxt;
            SCK        <= (state_nxt == HIGH);
            SSEL       <= !in_frame_nxt;
            busy       <= (state_nxt != IDLE) && !done_nxt;
            frame_done <= done_nxt;
            rx_valid   <= byte_end;
            if (byte_end) begin
                rx_data  <= {shreg[6:0], MISO};
                byte_idx <= byte_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sample) begin
            shreg <= {shreg[6:0], MISO};
        end
    end

`ifdef SPI_MASTER_MOSI_EN
    logic [7:0] tx_shreg, tx_nxt;

    always_comb begin
        tx_nxt = tx_shreg;
        if (byte_start) begin
            tx_nxt = tx_data;
        end else if (bit_shift) begin
            tx_nxt = {tx_shreg[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        tx_shreg <= tx_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MOSI <= 1'b0;
        end else begin
            MOSI <= in_frame_nxt && tx_nxt[7];
        end
    end
`else
    // Receive-only build: no transmit path.
`endif

endmodule

// File: tb/tb_spi_master_reader.sv
// tb_spi_master_reader
//   Directed bench for spi_master_reader. Instance A reads one byte per
//   frame, instance B four; both use CLK_DIV=4. Each instance has an ideal
//   slave model (bit7 presented while SSEL is low, shift after every SCK
//   rising edge) and a monitor that logs SSEL/SCK edges and strobes with
//   cycle stamps. Define SPI_MASTER_MOSI_EN to also exercise MOSI loopback.
module tb_spi_master_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: 1 byte per frame ----------------
    logic       start_a = 1'b0, busy_a, SCK_a, SSEL_a, MISO_a, rx_valid_a, frame_done_a;
    logic [7:0] rx_data_a, byte_idx_a;
    logic [7:0] sb_a [4];
    logic [5:0] sh_a;
    logic       clr_a = 1'b1, sck_qa, ssel_qa;
    int         rx_na, fd_na, fall_na, low_na, rise_na, fd_ca, last_low_a, rise_first_a, rise_last_a;
    int         rx_ca [8];
    logic [7:0] rx_da [8], rx_ia [8];
    int         fall_ca [4];

    // ---------------- instance B: 4 bytes per frame ----------------
    logic       start_b = 1'b0, busy_b, SCK_b, SSEL_b, MISO_b, rx_valid_b, frame_done_b;
    logic [7:0] rx_data_b, byte_idx_b;
    logic [7:0] sb_b [4];
    logic [5:0] sh_b;
    logic       clr_b = 1'b1, sck_qb, ssel_qb;
    int         rx_nb, fd_nb, fall_nb, low_nb, rise_nb, fd_cb, last_low_b, rise_first_b, rise_last_b;
    int         rx_cb [8];
    logic [7:0] rx_db [8], rx_ib [8];
    int         fall_cb [4];

`ifdef SPI_MASTER_MOSI_EN
    logic [7:0] tx_data_a = 8'h00, tx_data_b = 8'h00;
    logic       MOSI_a, MOSI_b;
    logic       loop_a = 1'b0;
    logic       mosi_qa;
    logic [7:0] mosi_bits;
    int         mosi_n, mosi_unstable;
    assign MISO_a = loop_a ? MOSI_a : sb_a[sh_a[4:3]][~sh_a[2:0]];
`else
    assign MISO_a = sb_a[sh_a[4:3]][~sh_a[2:0]];
`endif
    assign MISO_b = sb_b[sh_b[4:3]][~sh_b[2:0]];

    spi_master_reader #(.CLK_DIV(4), .BYTES_PER_FRAME(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .SCK(SCK_a), .SSEL(SSEL_a),
        .MISO(MISO_a),
`ifdef SPI_MASTER_MOSI_EN
        .tx_data(tx_data_a), .MOSI(MOSI_a),
`endif
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .byte_idx(byte_idx_a), .frame_done(frame_done_a)
    );

    spi_master_reader #(.CLK_DIV(4), .BYTES_PER_FRAME(4)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .SCK(SCK_b), .SSEL(SSEL_b),
        .MISO(MISO_b),
`ifdef SPI_MASTER_MOSI_EN
        .tx_data(tx_data_b), .MOSI(MOSI_b),
`endif
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .byte_idx(byte_idx_b), .frame_done(frame_done_b)
    );

    // Slave model and event log, sampled on the falling clk edge.
    always @(negedge clk) begin
        sck_qa  <= SCK_a;
        ssel_qa <= SSEL_a;
`ifdef SPI_MASTER_MOSI_EN
        mosi_qa <= MOSI_a;
`endif
        if (clr_a) begin
            rx_na <= 0; fd_na <= 0; fall_na <= 0; low_na <= 0; rise_na <= 0; sh_a <= 6'd0;
`ifdef SPI_MASTER_MOSI_EN
            mosi_n <= 0; mosi_unstable <= 0; mosi_bits <= 8'd0;
`endif
        end else begin
            if (SSEL_a) sh_a <= 6'd0;
            else if (SCK_a && !sck_qa) sh_a <= sh_a + 6'd1;
            if (!SSEL_a) begin low_na <= low_na + 1; last_low_a <= cyc; end
            if (!SSEL_a && ssel_qa) begin fall_ca[fall_na[1:0]] <= cyc; fall_na <= fall_na + 1; end
            if (SCK_a && !sck_qa) begin
                if (rise_na == 0) rise_first_a <= cyc;
                rise_last_a <= cyc;
                rise_na <= rise_na + 1;
`ifdef SPI_MASTER_MOSI_EN
                mosi_bits <= {mosi_bits[6:0], MOSI_a};
                mosi_n <= mosi_n + 1;
                if (MOSI_a !== mosi_qa) mosi_unstable <= mosi_unstable + 1;
`endif
            end
            if (rx_valid_a) begin
                rx_ca[rx_na[2:0]] <= cyc; rx_da[rx_na[2:0]] <= rx_data_a; rx_ia[rx_na[2:0]] <= byte_idx_a;
                rx_na <= rx_na + 1;
            end
            if (frame_done_a) begin fd_ca <= cyc; fd_na <= fd_na + 1; end
        end
    end

    always @(negedge clk) begin
        sck_qb  <= SCK_b;
        ssel_qb <= SSEL_b;
        if (clr_b) begin
            rx_nb <= 0; fd_nb <= 0; fall_nb <= 0; low_nb <= 0; rise_nb <= 0; sh_b <= 6'd0;
        end else begin
            if (SSEL_b) sh_b <= 6'd0;
            else if (SCK_b && !sck_qb) sh_b <= sh_b + 6'd1;
            if (!SSEL_b) begin low_nb <= low_nb + 1; last_low_b <= cyc; end
            if (!SSEL_b && ssel_qb) begin fall_cb[fall_nb[1:0]] <= cyc; fall_nb <= fall_nb + 1; end
            if (SCK_b && !sck_qb) begin
                if (rise_nb == 0) rise_first_b <= cyc;
                rise_last_b <= cyc;
                rise_nb <= rise_nb + 1;
            end
            if (rx_valid_b) begin
                rx_cb[rx_nb[2:0]] <= cyc; rx_db[rx_nb[2:0]] <= rx_data_b; rx_ib[rx_nb[2:0]] <= byte_idx_b;
                rx_nb <= rx_nb + 1;
            end
            if (frame_done_b) begin fd_cb <= cyc; fd_nb <= fd_nb + 1; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [7:0] slave;
        logic [7:0] exp_rx;
    } sb_vec_t;

    typedef struct {
        logic [31:0] slave;   // byte 0 in bits 31:24
        logic [31:0] exp_rx;
    } mb_vec_t;

    sb_vec_t sv [4];
    mb_vec_t mv [2];
    int      t0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sv[0] = '{8'hA5, 8'hA5};
        sv[1] = '{8'h00, 8'h00};
        sv[2] = '{8'hFF, 8'hFF};
        sv[3] = '{8'h96, 8'h96};
        mv[0] = '{32'h3CFF0081, 32'h3CFF0081};
        mv[1] = '{32'hA55A0180, 32'hA55A0180};
        for (int i = 0; i < 4; i++) begin sb_a[i] = 8'h00; sb_b[i] = 8'h00; end

        // reset
        rst = 1'b1;
        repeat (3) tick();
        check("rst_sck", SCK_a | SCK_b, 0);
        check("rst_ssel", SSEL_a & SSEL_b, 1);
        check("rst_busy", busy_a | busy_b, 0);
        check("rst_rx_data", {rx_data_a, rx_data_b}, 0);
        check("rst_byte_idx", {byte_idx_a, byte_idx_b}, 0);
        rst = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        repeat (50) tick();
        check("idle_sck", SCK_a | SCK_b, 0);
        check("idle_ssel", SSEL_a & SSEL_b, 1);
        check("idle_busy", busy_a | busy_b, 0);
        check("idle_strobes", rx_na + rx_nb + fd_na + fd_nb, 0);

        // single-byte frames
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 4; n++) sb_a[n] = sv[i].slave;
            clr_a = 1'b1; tick(); clr_a = 1'b0; tick();
            start_a = 1'b1; t0 = cyc; tick(); start_a = 1'b0;
            check($sformatf("sb%0d_busy_on", i), busy_a, 1);
            for (int k = 0; k < 200 && fd_na < 1; k++) tick();
            check($sformatf("sb%0d_fd_count", i), fd_na, 1);
            check($sformatf("sb%0d_ssel_fall", i), fall_ca[0], t0 + 1);
            check($sformatf("sb%0d_ssel_last", i), last_low_a, t0 + 68);
            check($sformatf("sb%0d_ssel_len", i), low_na, 68);
            check($sformatf("sb%0d_sck_rises", i), rise_na, 8);
            check($sformatf("sb%0d_rx_count", i), rx_na, 1);
            check($sformatf("sb%0d_rx_data", i), rx_da[0], sv[i].exp_rx);
            check($sformatf("sb%0d_byte_idx", i), rx_ia[0], 0);
            check($sformatf("sb%0d_rx_cycle", i), rx_ca[0], t0 + 61);
            check($sformatf("sb%0d_fd_cycle", i), fd_ca, t0 + 72);
            check($sformatf("sb%0d_busy_off", i), busy_a, 0);
        end

        // four-byte frames
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 4; n++) sb_b[n] = mv[i].slave[31 - 8*n -: 8];
            clr_b = 1'b1; tick(); clr_b = 1'b0; tick();
            start_b = 1'b1; t0 = cyc; tick(); start_b = 1'b0;
            for (int k = 0; k < 400 && fd_nb < 1; k++) tick();
            check($sformatf("mb%0d_fd_count", i), fd_nb, 1);
            check($sformatf("mb%0d_ssel_fall", i), fall_cb[0], t0 + 1);
            check($sformatf("mb%0d_ssel_len", i), low_nb, 260);
            check($sformatf("mb%0d_ssel_last", i), last_low_b, t0 + 260);
            check($sformatf("mb%0d_sck_rises", i), rise_nb, 32);
            check($sformatf("mb%0d_sck_span", i), rise_last_b - rise_first_b, 248);
            check($sformatf("mb%0d_rx_count", i), rx_nb, 4);
            for (int n = 0; n < 4; n++) begin
                check($sformatf("mb%0d_rx_data%0d", i, n), rx_db[n], mv[i].exp_rx[31 - 8*n -: 8]);
                check($sformatf("mb%0d_byte_idx%0d", i, n), rx_ib[n], n);
                check($sformatf("mb%0d_rx_cycle%0d", i, n), rx_cb[n], t0 + 61 + 64*n);
            end
            check($sformatf("mb%0d_fd_cycle", i), fd_cb, t0 + 264);
        end

        // start while busy and on the frame_done cycle is ignored;
        // start on the first IDLE cycle afterwards launches a new frame
        for (int n = 0; n < 4; n++) sb_b[n] = mv[0].slave[31 - 8*n -: 8];
        clr_b = 1'b1; tick(); clr_b = 1'b0; tick();
        start_b = 1'b1; t0 = cyc; tick(); start_b = 1'b0;
        while (cyc < t0 + 100) tick();
        start_b = 1'b1; tick(); start_b = 1'b0;
        while (cyc < t0 + 264) tick();
        start_b = 1'b1; tick(); tick(); start_b = 1'b0;
        check("ign_fd_first", fd_cb, t0 + 264);
        for (int k = 0; k < 400 && fd_nb < 2; k++) tick();
        check("ign_fd_count", fd_nb, 2);
        check("ign_frames", fall_nb, 2);
        check("ign_second_fall", fall_cb[1], t0 + 266);
        check("ign_second_fd", fd_cb, t0 + 529);
        check("ign_rx_count", rx_nb, 8);
        check("ign_second_b0", rx_db[4], 8'h3C);
        check("ign_second_b3", rx_db[7], 8'h81);

        // reset during byte 1 bit 3
        clr_b = 1'b1; tick(); clr_b = 1'b0; tick();
        start_b = 1'b1; t0 = cyc; tick(); start_b = 1'b0;
        while (cyc < t0 + 90) tick();
        check("mid_sck_before", SCK_b, 0);
        check("mid_ssel_before", SSEL_b, 0);
        rst = 1'b1; tick();
        check("mid_ssel", SSEL_b, 1);
        check("mid_sck", SCK_b, 0);
        check("mid_busy", busy_b, 0);
        rst = 1'b0;
        repeat (300) tick();
        check("mid_rx_count", rx_nb, 1);
        check("mid_fd_count", fd_nb, 0);
        check("mid_byte0", rx_db[0], 8'h3C);
        clr_b = 1'b1; tick(); clr_b = 1'b0; tick();
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int k = 0; k < 400 && fd_nb < 1; k++) tick();
        check("mid_restart_fd", fd_nb, 1);
        check("mid_restart_b0", rx_db[0], 8'h3C);
        check("mid_restart_idx0", rx_ib[0], 0);
        check("mid_restart_b1", rx_db[1], 8'hFF);

`ifdef SPI_MASTER_MOSI_EN
        // MOSI loopback into MISO
        loop_a = 1'b1; tx_data_a = 8'hC3;
        clr_a = 1'b1; tick(); clr_a = 1'b0; tick();
        check("mosi_idle", MOSI_a, 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("mosi_first_bit", MOSI_a, 1);
        for (int k = 0; k < 200 && fd_na < 1; k++) tick();
        check("mosi_fd_count", fd_na, 1);
        check("mosi_bit_count", mosi_n, 8);
        check("mosi_bits", mosi_bits, 8'hC3);
        check("mosi_unstable", mosi_unstable, 0);
        check("mosi_loop_rx", rx_da[0], 8'hC3);
        check("mosi_after", MOSI_a, 0);
        loop_a = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
